// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker: FSM state encoding
// and the default frame width.
package serial_parity_checker_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/serial_parity_checker_parity_acc.sv
// Running parity accumulator: a 1-bit register that XORs in each qualified
// serial bit, with a synchronous clear for the start of a frame.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic acc
);

  logic acc_next;

  xor u_xor2 (acc_next, acc, din);

  // Parity register: clear wins over enable so a new frame always starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= 1'b0;
    else if (clr)
      acc <= 1'b0;
    else if (en)
      acc <= acc_next;
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: collects DATA_BITS data bits (LSB first) followed by
// one parity bit, then reports the word and whether its parity matched.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last frame's result
// DATA    | shifting in data bits on each bit_en cycle
// PAR     | waiting for the parity bit on the next bit_en cycle
// DONE    | one-cycle done pulse, then back to IDLE
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter bit ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_en,
  input  logic                 din,
  output logic                 busy,
  output logic                 done,
  output logic                 parity_ok,
  output logic [DATA_BITS-1:0] data_out
);

  localparam int CNT_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             acc_clr;
  logic             acc_en;
  logic [DATA_BITS-1:0] din_word;

  assign acc_clr  = (state == ST_IDLE) && start;
  assign acc_en   = (state == ST_DATA) && bit_en;
  assign din_word = {{(DATA_BITS-1){1'b0}}, din};

  parity_acc u_parity_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (din),
    .acc   (acc)
  );

  // Frame FSM with counter, data shift register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      parity_ok <= 1'b0;
      data_out  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_DATA;
            cnt       <= '0;
            busy      <= 1'b1;
            parity_ok <= 1'b0;
            // Bits not yet received must read 0, so the old word is dropped here.
            data_out  <= '0;
          end
        end
        ST_DATA: begin
          if (bit_en) begin
            data_out <= data_out | (din_word << cnt);
            cnt      <= cnt + 1'b1;
            if (cnt == CNT_LAST)
              state <= ST_PAR;
          end
        end
        ST_PAR: begin
          if (bit_en) begin
            parity_ok <= ((acc ^ din) == ODD);
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 Parameter DATA_BITS, default 8, number of serial data bits per frame (range 2..32).
REQ-002 Parameter ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  frame-start pulse; sampled only in IDLE.
REQ-006 bit_en  input  1  qualifies din as the next frame bit; low = stall.
REQ-007 din  input  1  serial bit, data LSB first, followed by one parity bit.
REQ-008 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-009 done  output  1  one-cycle pulse when frame checking completes.
REQ-010 parity_ok  output  1  frame result, valid from done and held until the next accepted start.
REQ-011 data_out  output  DATA_BITS  received data word, valid from done and held until the next accepted start.

Function
REQ-012 FSM states: IDLE, DATA, PAR, DONE; registered state, one-hot or binary encoding.
REQ-013 IDLE: start=1 -> DATA; clear bit counter and parity accumulator to 0; clear parity_ok to 0.
REQ-014 DATA: each cycle with bit_en=1, shift din into data_out at bit [cnt] (LSB first), set acc <= acc XOR din, and increment cnt.
REQ-015 DATA: on the bit_en cycle where cnt = DATA_BITS-1 -> PAR.
REQ-016 PAR: on the bit_en=1 cycle, set parity_ok <= ((acc XOR din) == ODD) and go to DONE.
REQ-017 DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
REQ-018 Latency from the parity-bit bit_en edge to done high is one clock.
REQ-019 bit_en=0 in DATA or PAR holds all state (stall); the frame has no timeout.
REQ-020 start is ignored outside IDLE; bit_en and din are ignored in IDLE and DONE.
REQ-021 start and bit_en high in the same IDLE cycle: only the start is taken; the bit is not captured.
REQ-022 The bit counter width is clog2(DATA_BITS)+1; it never wraps within a frame.
REQ-023 data_out bits not yet received in the current frame read 0.

Reset
REQ-024 With rst_n low: state=IDLE, busy=0, done=0, parity_ok=0, data_out=0, cnt=0, acc=0, asynchronously.
REQ-025 Reset asserted mid-frame discards the partial frame and produces no done pulse.
REQ-026 After reset deassertion, the first rising edge may accept start.

Structure
REQ-027 State encodings and the default DATA_BITS value reside in a shared include file, serial_parity_defs.vh.
REQ-028 The parity accumulator is one sub-module, parity_acc (1-bit register with clear, enable, XOR-in), built structurally from the team's 2-input XOR gate.
REQ-029 The remaining FSM, counter and shift logic stays in serial_parity_checker; target 120-400 lines total.

Verification
REQ-030 Even parity, DATA_BITS=8: start, then bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), then parity 0 -> done pulse, data_out=0xA5, parity_ok=1.
REQ-031 Same frame with parity bit 1 -> data_out=0xA5, parity_ok=0.
REQ-032 ODD=1: frame 0x01 with parity 0 -> parity_ok=1; frame 0x03 with parity 0 -> parity_ok=0.
REQ-033 Frame 0xFF with bit_en low for 3 cycles between bits 4 and 5 -> result identical to the unstalled frame; busy stays high throughout the stall.
REQ-034 Assert rst_n=0 after 4 data bits -> all outputs 0 immediately; no done; a following full frame 0x3C with parity 0 -> parity_ok=1.
REQ-035 Pulse start while busy, and drive bit_en in IDLE -> no effect on the counter or data_out; done occurs exactly once per accepted frame.
